// File: rtl/router_pkt_tx_if.sv
// router_pkt_tx_if: source-side and crossbar-side signals of one packet
// injector. The injector takes the slave view; the driving side (source
// plus crossbar model) takes the master view.
interface router_pkt_tx_if;
    // local source side
    logic [63:0] S_D;
    logic [7:0]  S_DEST;
    logic        S_SOF;
    logic        S_EOF;
    logic        S_VALID;
    logic        S_READY;
    // crossbar ingress side
    logic [63:0] D;
    logic [7:0]  DEST;
    logic        DEST_VALID;
    logic        D_HDR_VALID;
    logic        D_PLD_VALID;
    logic        D_SOF;
    logic        D_EOF;
    logic        D_BP;
    logic        COLLISION;
    logic        DROP;

    modport master (
        output S_D, S_DEST, S_SOF, S_EOF, S_VALID, D_BP, COLLISION,
        input  S_READY, D, DEST, DEST_VALID, D_HDR_VALID, D_PLD_VALID,
               D_SOF, D_EOF, DROP
    );

    modport slave (
        input  S_D, S_DEST, S_SOF, S_EOF, S_VALID, D_BP, COLLISION,
        output S_READY, D, DEST, DEST_VALID, D_HDR_VALID, D_PLD_VALID,
               D_SOF, D_EOF, DROP
    );
endinterface

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: store-and-forward packet injector for one crossbar ingress
// port. Whole packets are buffered, then framed onto the crossbar with
// backpressure handling; a destination collision rewinds the packet.
// Optional feature macro: ROUTER_PKT_TX_RETRY_EN
//   defined   - collision rewinds, backs off RetryGap cycles and resends,
//               dropping the packet after MaxRetry retries
//   undefined - any collision drops the packet immediately
module router_pkt_tx #(
    parameter int unsigned Depth    = 16,
    parameter int unsigned MaxRetry = 3,
    parameter int unsigned RetryGap = 4
) (
    input  logic           CLK,
    input  logic           RST,
    router_pkt_tx_if.slave bus
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned EW = 74;

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("router_pkt_tx: Depth must be a power of 2 and >= 2");
    end
    if (MaxRetry < 1 || MaxRetry > 255) begin : g_bad_retry
        $error("router_pkt_tx: MaxRetry must be in 1..255");
    end
    if (RetryGap < 1 || RetryGap > 255) begin : g_bad_gap
        $error("router_pkt_tx: RetryGap must be in 1..255");
    end

`ifdef ROUTER_PKT_TX_RETRY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_BACKOFF, ST_DROP} state_t;
    localparam logic [7:0] MAX_RETRY = 8'(MaxRetry);
    localparam logic [7:0] RETRY_GAP = 8'(RetryGap);
    logic [7:0] retry_cnt, retry_nx;
    logic [7:0] gap_cnt, gap_nx;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DROP} state_t;
`endif

    state_t state, state_nx;

    // entry layout: {data[63:0], dest[7:0], sof, eof}
    logic [EW-1:0] mem [Depth];
    logic [AW:0]   wr_ptr, rd_ptr, cm_ptr;
    logic [AW:0]   rd_ptr_nx, cm_ptr_nx;
    logic [AW:0]   pkt_cnt;
    logic          pkt_inc, pkt_dec;
    logic          full, ready, wr_en;
    logic [EW-1:0] head;
    logic          cm_eof;

    // space is reckoned from the commit pointer so a rewind never finds
    // its packet overwritten
    assign full    = (wr_ptr[AW] != cm_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == cm_ptr[AW-1:0]);
    assign ready   = !full;
    assign wr_en   = bus.S_VALID && ready;
    assign pkt_inc = wr_en && bus.S_EOF;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign cm_eof  = mem[cm_ptr[AW-1:0]][0];

    assign bus.S_READY = ready;

    // FIFO storage write
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {bus.S_D, bus.S_DEST, bus.S_SOF, bus.S_EOF};
        end
    end

    // state, pointers and counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cm_ptr  <= '0;
            pkt_cnt <= '0;
`ifdef ROUTER_PKT_TX_RETRY_EN
            retry_cnt <= '0;
            gap_cnt   <= '0;
`endif
        end else begin
            state  <= state_nx;
            rd_ptr <= rd_ptr_nx;
            cm_ptr <= cm_ptr_nx;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            unique case ({pkt_inc, pkt_dec})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
`ifdef ROUTER_PKT_TX_RETRY_EN
            retry_cnt <= retry_nx;
            gap_cnt   <= gap_nx;
`endif
        end
    end

    // next-state decode and crossbar outputs from registered state + memory
    always_comb begin
        state_nx        = state;
        rd_ptr_nx       = rd_ptr;
        cm_ptr_nx       = cm_ptr;
        pkt_dec         = 1'b0;
`ifdef ROUTER_PKT_TX_RETRY_EN
        retry_nx        = retry_cnt;
        gap_nx          = gap_cnt;
`endif
        bus.D           = '0;
        bus.DEST        = '0;
        bus.DEST_VALID  = 1'b0;
        bus.D_HDR_VALID = 1'b0;
        bus.D_PLD_VALID = 1'b0;
        bus.D_SOF       = 1'b0;
        bus.D_EOF       = 1'b0;
        bus.DROP        = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (pkt_cnt != '0) begin
                    rd_ptr_nx = cm_ptr;
                    state_nx  = ST_SEND;
                end
            end

            ST_SEND: begin
                bus.D           = head[73:10];
                bus.DEST        = head[9:2];
                bus.DEST_VALID  = 1'b1;
                bus.D_HDR_VALID = head[1];
                bus.D_PLD_VALID = !head[1];
                bus.D_SOF       = head[1];
                bus.D_EOF       = head[0];
                // collision outranks a same-cycle EOF transfer
                if (bus.COLLISION) begin
                    rd_ptr_nx = cm_ptr;
`ifdef ROUTER_PKT_TX_RETRY_EN
                    if (retry_cnt == MAX_RETRY) begin
                        state_nx = ST_DROP;
                    end else begin
                        retry_nx = retry_cnt + 1'b1;
                        gap_nx   = RETRY_GAP;
                        state_nx = ST_BACKOFF;
                    end
`else
                    state_nx = ST_DROP;
`endif
                end else if (!bus.D_BP) begin
                    rd_ptr_nx = rd_ptr + 1'b1;
                    if (head[0]) begin
                        cm_ptr_nx = rd_ptr + 1'b1;
                        pkt_dec   = 1'b1;
`ifdef ROUTER_PKT_TX_RETRY_EN
                        retry_nx  = '0;
`endif
                        state_nx  = ST_IDLE;
                    end
                end
            end

`ifdef ROUTER_PKT_TX_RETRY_EN
            // counting down through zero gives RetryGap+1 dark cycles
            // between the collision sample and the resent SOF
            ST_BACKOFF: begin
                if (gap_cnt == '0) begin
                    state_nx = ST_SEND;
                end else begin
                    gap_nx = gap_cnt - 1'b1;
                end
            end
`endif

            ST_DROP: begin
                cm_ptr_nx = cm_ptr + 1'b1;
                if (cm_eof) begin
                    bus.DROP = 1'b1;
                    pkt_dec  = 1'b1;
`ifdef ROUTER_PKT_TX_RETRY_EN
                    retry_nx = '0;
`endif
                    state_nx = ST_IDLE;
                end
            end

            default: state_nx = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed self-checking bench for router_pkt_tx.
// Expectations follow ROUTER_PKT_TX_RETRY_EN the same way the design does.
module tb_router_pkt_tx;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    router_pkt_tx_if bus ();

    router_pkt_tx #(
        .Depth    (16),
        .MaxRetry (3),
        .RetryGap (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // {DEST_VALID, D_HDR_VALID, D_PLD_VALID, D_SOF, D_EOF, DROP}
    function automatic logic [5:0] flags();
        return {bus.DEST_VALID, bus.D_HDR_VALID, bus.D_PLD_VALID,
                bus.D_SOF, bus.D_EOF, bus.DROP};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic [7:0] dest,
                        input logic sof, input logic eof);
        int unsigned w = 0;
        bus.S_D     = d;
        bus.S_DEST  = dest;
        bus.S_SOF   = sof;
        bus.S_EOF   = eof;
        bus.S_VALID = 1'b1;
        while (!bus.S_READY && w < 50) begin
            tick();
            w++;
        end
        if (!bus.S_READY) begin
            checks++;
            errors++;
            $display("FAIL push_timeout S_READY got %b exp 1", bus.S_READY);
        end
        tick();
        bus.S_VALID = 1'b0;
        bus.S_SOF   = 1'b0;
        bus.S_EOF   = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.S_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", bus.S_READY);
        end
        checks++;
        if (bus.D !== 64'h0 || bus.DEST !== 8'h0) begin
            errors++;
            $display("FAIL reset_data got D=%h DEST=%h exp 0/0", bus.D, bus.DEST);
        end
        checks++;
        if (flags() !== 6'b000000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000000", flags());
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_single();
        push(64'hA5, 8'h02, 1'b1, 1'b1);
        // one edge after the EOF is accepted: still IDLE
        checks++;
        if (flags() !== 6'b000000) begin
            errors++;
            $display("FAIL single_latency got %b exp 000000", flags());
        end
        tick();
        checks++;
        if (bus.D !== 64'hA5 || bus.DEST !== 8'h02) begin
            errors++;
            $display("FAIL single_data got D=%h DEST=%h exp a5/02", bus.D, bus.DEST);
        end
        checks++;
        if (flags() !== 6'b110110) begin
            errors++;
            $display("FAIL single_flags got %b exp 110110", flags());
        end
        tick();
        checks++;
        if (flags() !== 6'b000000) begin
            errors++;
            $display("FAIL single_end got %b exp 000000", flags());
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] wexp [7];
        logic [5:0]  fexp [7];
        logic        bp   [7];
        wexp = '{64'h1000, 64'h1001, 64'h1001, 64'h1001, 64'h1001, 64'h1002, 64'h1003};
        fexp = '{6'b110100, 6'b101000, 6'b101000, 6'b101000, 6'b101000,
                 6'b101000, 6'b101010};
        bp   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int unsigned i = 0; i < 4; i++) begin
            push(64'h1000 + 64'(i), 8'h05, i == 0, i == 3);
        end
        tick();
        for (int unsigned i = 0; i < 7; i++) begin
            bus.D_BP = bp[i];
            checks++;
            if (bus.D !== wexp[i] || bus.DEST !== 8'h05) begin
                errors++;
                $display("FAIL bp_word[%0d] got D=%h DEST=%h exp %h/05", i, bus.D, bus.DEST, wexp[i]);
            end
            checks++;
            if (flags() !== fexp[i]) begin
                errors++;
                $display("FAIL bp_flags[%0d] got %b exp %b", i, flags(), fexp[i]);
            end
            tick();
        end
        bus.D_BP = 1'b0;
        checks++;
        if (flags() !== 6'b000000) begin
            errors++;
            $display("FAIL bp_end got %b exp 000000", flags());
        end
    endtask

    task automatic test_collision();
        for (int unsigned i = 0; i < 4; i++) begin
            push(64'h2000 + 64'(i), 8'h06, i == 0, i == 3);
        end
        tick();
        checks++;
        if (bus.D !== 64'h2000 || flags() !== 6'b110100) begin
            errors++;
            $display("FAIL coll_first got D=%h F=%b exp 2000/110100", bus.D, flags());
        end
        tick();
        bus.COLLISION = 1'b1;
        checks++;
        if (bus.D !== 64'h2001 || flags() !== 6'b101000) begin
            errors++;
            $display("FAIL coll_w1 got D=%h F=%b exp 2001/101000", bus.D, flags());
        end
        tick();
        bus.COLLISION = 1'b0;
`ifdef ROUTER_PKT_TX_RETRY_EN
        for (int unsigned i = 0; i < 5; i++) begin
            checks++;
            if (flags() !== 6'b000000) begin
                errors++;
                $display("FAIL coll_gap[%0d] got %b exp 000000", i, flags());
            end
            tick();
        end
        for (int unsigned i = 0; i < 4; i++) begin
            logic [5:0] fe;
            fe = (i == 0) ? 6'b110100 : ((i == 3) ? 6'b101010 : 6'b101000);
            checks++;
            if (bus.D !== 64'h2000 + 64'(i) || flags() !== fe) begin
                errors++;
                $display("FAIL coll_resend[%0d] got D=%h F=%b exp %h/%b", i, bus.D, flags(), 64'h2000 + 64'(i), fe);
            end
            tick();
        end
        checks++;
        if (flags() !== 6'b000000) begin
            errors++;
            $display("FAIL coll_end got %b exp 000000", flags());
        end
`else
        for (int unsigned i = 0; i < 6; i++) begin
            logic [5:0] fe;
            fe = (i == 3) ? 6'b000001 : 6'b000000;
            checks++;
            if (flags() !== fe) begin
                errors++;
                $display("FAIL coll_drop[%0d] got %b exp %b", i, flags(), fe);
            end
            tick();
        end
`endif
    endtask

    task automatic test_drop();
        int          sof_a  = 0;
        int          drops  = 0;
        int          k_coll = -1;
        int          k_drop = -1;
        int          k_b    = -1;
        logic [63:0] b_data = '0;
        int          exp_sof;
`ifdef ROUTER_PKT_TX_RETRY_EN
        exp_sof = 4;
`else
        exp_sof = 1;
`endif
        push(64'h3000, 8'h03, 1'b1, 1'b0);
        push(64'h3001, 8'h03, 1'b0, 1'b1);
        push(64'h4000, 8'h04, 1'b1, 1'b1);
        for (int cyc = 0; cyc < 100 && k_b < 0; cyc++) begin
            bus.COLLISION = 1'b0;
            if (bus.DROP) begin
                drops++;
                k_drop = cyc;
            end
            if (bus.DEST_VALID && bus.D_SOF && bus.DEST == 8'h03) begin
                sof_a++;
                bus.COLLISION = 1'b1;
                k_coll = cyc;
            end
            if (bus.DEST_VALID && bus.D_SOF && bus.DEST == 8'h04) begin
                k_b    = cyc;
                b_data = bus.D;
            end
            if (k_b < 0) tick();
        end
        bus.COLLISION = 1'b0;
        checks++;
        if (sof_a !== exp_sof) begin
            errors++;
            $display("FAIL drop_attempts got %0d exp %0d", sof_a, exp_sof);
        end
        checks++;
        if (drops !== 1) begin
            errors++;
            $display("FAIL drop_pulses got %0d exp 1", drops);
        end
        checks++;
        if (k_drop - k_coll !== 2) begin
            errors++;
            $display("FAIL drop_timing got %0d exp 2", k_drop - k_coll);
        end
        checks++;
        if (k_b - k_coll !== 4 || b_data !== 64'h4000) begin
            errors++;
            $display("FAIL drop_next got dt=%0d D=%h exp 4/4000", k_b - k_coll, b_data);
        end
        tick();
        tick();
        checks++;
        if (flags() !== 6'b000000) begin
            errors++;
            $display("FAIL drop_end got %b exp 000000", flags());
        end
    endtask

    task automatic test_fill();
        bus.D_BP = 1'b1;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i == 15) begin
                checks++;
                if (bus.S_READY !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_ready15 got %b exp 1", bus.S_READY);
                end
            end
            push(64'h5000 + 64'(i), 8'h08, (i % 8) == 0, (i % 8) == 7);
        end
        checks++;
        if (bus.S_READY !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got %b exp 0", bus.S_READY);
        end
        bus.D_BP = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            checks++;
            if (bus.S_READY !== 1'b0 || bus.D !== 64'h5000 + 64'(i)) begin
                errors++;
                $display("FAIL fill_drain[%0d] got R=%b D=%h exp 0/%h", i, bus.S_READY, bus.D, 64'h5000 + 64'(i));
            end
            tick();
        end
        checks++;
        if (bus.S_READY !== 1'b1 || flags() !== 6'b000000) begin
            errors++;
            $display("FAIL fill_commit got R=%b F=%b exp 1/000000", bus.S_READY, flags());
        end
        tick();
        checks++;
        if (bus.D !== 64'h5008 || flags() !== 6'b110100) begin
            errors++;
            $display("FAIL fill_pkt2 got D=%h F=%b exp 5008/110100", bus.D, flags());
        end
        for (int unsigned i = 0; i < 8; i++) tick();
        checks++;
        if (flags() !== 6'b000000 || bus.S_READY !== 1'b1) begin
            errors++;
            $display("FAIL fill_end got F=%b R=%b exp 000000/1", flags(), bus.S_READY);
        end
    endtask

    task automatic test_reset_mid();
        for (int unsigned i = 0; i < 4; i++) begin
            push(64'h6000 + 64'(i), 8'h07, i == 0, i == 3);
        end
        tick();
        tick();
        checks++;
        if (bus.D !== 64'h6001) begin
            errors++;
            $display("FAIL rstmid_pre got D=%h exp 6001", bus.D);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (flags() !== 6'b000000 || bus.D !== 64'h0 || bus.DEST !== 8'h0 || bus.S_READY !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_out got F=%b D=%h DEST=%h R=%b exp 000000/0/0/1", flags(), bus.D, bus.DEST, bus.S_READY);
        end
        tick();
        tick();
        checks++;
        if (flags() !== 6'b000000) begin
            errors++;
            $display("FAIL rstmid_flushed got %b exp 000000", flags());
        end
        push(64'hC3, 8'h09, 1'b1, 1'b1);
        tick();
        checks++;
        if (bus.D !== 64'hC3 || bus.DEST !== 8'h09 || flags() !== 6'b110110) begin
            errors++;
            $display("FAIL rstmid_next got D=%h DEST=%h F=%b exp c3/09/110110", bus.D, bus.DEST, flags());
        end
        tick();
        tick();
        checks++;
        if (flags() !== 6'b000000) begin
            errors++;
            $display("FAIL rstmid_end got %b exp 000000", flags());
        end
    endtask

    initial begin
        bus.S_D       = '0;
        bus.S_DEST    = '0;
        bus.S_SOF     = 1'b0;
        bus.S_EOF     = 1'b0;
        bus.S_VALID   = 1'b0;
        bus.D_BP      = 1'b0;
        bus.COLLISION = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_collision();
        test_drop();
        test_fill();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
